// File: rtl/p2s_tx_scheduler_if.sv
// Request/serial bundle between the word producers and the shared transmit lane.
// The scheduler takes the slave view; the producers drive through the master view.
interface p2s_tx_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int OW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       grant;
  logic                   sout;
  logic                   VO;
  logic                   frame_start;
  logic                   OK;
  logic                   busy;
  logic [OW-1:0]          owner;

  modport master (
    output req, data_in,
    input  grant, sout, VO, frame_start, OK, busy, owner
  );

  modport slave (
    input  req, data_in,
    output grant, sout, VO, frame_start, OK, busy, owner
  );
endinterface

// File: rtl/p2s_tx_scheduler.sv
// Round-robin scheduler that serialises one requester's word at a time, MSB first,
// with a programmable idle gap after every frame.
module p2s_tx_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic               ck,
  input logic               reset,
  p2s_tx_scheduler_if.slave bus
);
  localparam int OW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [OW:0]   N_REQ_W  = (OW + 1)'(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_GAP   = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             ok_q, ok_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [OW-1:0]      sel_off;
  logic [OW:0]        sel_sum;
  logic [OW:0]        nxt_sum;
  logic [OW-1:0]      sel_idx;
  logic [OW-1:0]      sel_next;
  logic               sel_found;
  logic [WIDTH-1:0]   sel_word;
  logic               vo_w;

  // Rotate requests so bit 0 is the pointer position; the lowest set bit of the
  // rotated vector is the winner, and its offset is added back modulo N_REQ.
  always_comb begin
    req_dbl   = {bus.req, bus.req};
    req_rot   = N_REQ'(req_dbl >> ptr_q);
    sel_found = 1'b0;
    sel_off   = '0;
    for (int d = N_REQ - 1; d >= 0; d--) begin
      if (req_rot[d]) begin
        sel_found = 1'b1;
        sel_off   = OW'(d);
      end
    end
    sel_sum  = {1'b0, ptr_q} + {1'b0, sel_off};
    sel_idx  = (sel_sum >= N_REQ_W) ? OW'(sel_sum - N_REQ_W) : sel_sum[OW-1:0];
    nxt_sum  = {1'b0, sel_idx} + (OW + 1)'(1);
    sel_next = (nxt_sum >= N_REQ_W) ? OW'(nxt_sum - N_REQ_W) : nxt_sum[OW-1:0];
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == OW'(i)) begin
        sel_word = bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = '0;
    ok_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_SHIFT;
          shreg_d = sel_word;
          owner_d = sel_idx;
          ptr_d   = sel_next;
          cnt_d   = '0;
          grant_d = N_REQ'(1) << sel_idx;
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          ok_d  = 1'b1;
          cnt_d = '0;
          gap_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ok_q    <= ok_d;
    end
  end

  assign vo_w            = (state_q == S_SHIFT);
  assign bus.VO          = vo_w;
  assign bus.sout        = vo_w & shreg_q[WIDTH-1];
  assign bus.frame_start = vo_w & (cnt_q == '0);
  assign bus.grant       = grant_q;
  assign bus.OK          = ok_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.owner       = owner_q;
endmodule

// File: tb/tb_p2s_tx_scheduler.sv
// Directed bench for the shared serial transmit scheduler: a per-cycle vector table
// for a single frame, then hand-written sequences for arbitration, reset and GAP=0.
module tb_p2s_tx_scheduler;
  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       sout;
    logic       vo;
    logic       fs;
    logic       ok;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  logic ck      = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cycle_cnt = 0;
  vec_t vecs [13];

  p2s_tx_scheduler_if #(.N_REQ(4), .WIDTH(8)) bus_a ();
  p2s_tx_scheduler_if #(.N_REQ(2), .WIDTH(4)) bus_b ();

  p2s_tx_scheduler #(.N_REQ(4), .WIDTH(8), .GAP(1)) dut_a (
    .ck    (ck),
    .reset (reset_a),
    .bus   (bus_a)
  );

  p2s_tx_scheduler #(.N_REQ(2), .WIDTH(4), .GAP(0)) dut_b (
    .ck    (ck),
    .reset (reset_b),
    .bus   (bus_b)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cycle_cnt <= cycle_cnt + 1;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_a   = v.rst;
    bus_a.req = v.req;
    tick();
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d grant", idx), 32'(bus_a.grant), 32'(v.grant));
    checkOutput($sformatf("v%0d sout", idx), 32'(bus_a.sout), 32'(v.sout));
    checkOutput($sformatf("v%0d VO", idx), 32'(bus_a.VO), 32'(v.vo));
    checkOutput($sformatf("v%0d frame_start", idx), 32'(bus_a.frame_start), 32'(v.fs));
    checkOutput($sformatf("v%0d OK", idx), 32'(bus_a.OK), 32'(v.ok));
    checkOutput($sformatf("v%0d busy", idx), 32'(bus_a.busy), 32'(v.busy));
    checkOutput($sformatf("v%0d owner", idx), 32'(bus_a.owner), 32'(v.owner));
  endtask

  task automatic waitGrant(input int exp_idx, output int at_cycle);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus_a.grant == '0 && n < 30);
    if (bus_a.grant == '0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL grant_timeout: no grant within %0d cycles, required requester %0d", n, exp_idx);
    end
    checkOutput($sformatf("grant to %0d", exp_idx), 32'(bus_a.grant), 32'(1) << exp_idx);
    checkOutput($sformatf("owner %0d", exp_idx), 32'(bus_a.owner), 32'(exp_idx));
    at_cycle = cycle_cnt;
  endtask

  // Entered on the grant cycle, where the MSB is already on sout; leaves on the OK cycle.
  task automatic captureFrame(input logic [7:0] exp_word, input int drop_at);
    logic [7:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) begin
      if (b > 0) tick();
      if (b == drop_at) bus_a.req = '0;
      checkOutput($sformatf("VO bit %0d", b), 32'(bus_a.VO), 32'd1);
      checkOutput($sformatf("frame_start bit %0d", b), 32'(bus_a.frame_start),
                  (b == 0) ? 32'd1 : 32'd0);
      w[7-b] = bus_a.sout;
    end
    checkOutput("frame word", 32'(w), 32'(exp_word));
    tick();
    checkOutput("OK after frame", 32'(bus_a.OK), 32'd1);
    checkOutput("VO after frame", 32'(bus_a.VO), 32'd0);
    checkOutput("busy in gap", 32'(bus_a.busy), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t_prev;
    int t;
    int t_rel;
    int seq3 [3];
    int p;
    int f;
    int own;
    logic [3:0] word_b;
    logic [1:0] exp_grant_b;
    logic       exp_vo_b;
    logic       exp_sout_b;
    logic       exp_ok_b;
    logic       exp_busy_b;

    bus_a.req     = '0;
    bus_a.data_in = '0;
    bus_b.req     = '0;
    bus_b.data_in = '0;

    // Single requester 1 sending A5 = 1010_0101, then OK, one GAP cycle, IDLE.
    bus_a.data_in = 32'h0000_A500;
    //          rst   req   grant sout  vo    fs    ok    busy  owner
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[9]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[12] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Round-robin over all four requesters with a 10-cycle frame period.
    $display("[TB] round-robin sequence");
    reset_a = 1'b1;
    tick();
    tick();
    reset_a       = 1'b0;
    bus_a.req     = 4'b1111;
    bus_a.data_in = {8'h04, 8'h03, 8'h02, 8'h01};
    waitGrant(0, t_prev);
    captureFrame(8'h01, -1);
    for (int k = 1; k < 4; k++) begin
      waitGrant(k, t);
      checkOutput($sformatf("period to grant %0d", k), 32'(t - t_prev), 32'd10);
      t_prev = t;
      if (k == 3) bus_a.req = 4'b0101;
      captureFrame(8'(k + 1), -1);
    end

    // Pointer wraps past 3 and skips the idle requesters 1 and 3.
    seq3 = '{0, 2, 0};
    for (int k = 0; k < 3; k++) begin
      waitGrant(seq3[k], t);
      checkOutput($sformatf("wrap period %0d", k), 32'(t - t_prev), 32'd10);
      t_prev = t;
      captureFrame(8'(seq3[k] + 1), -1);
    end
    bus_a.req = '0;
    tick();

    // Reset at bit 3 aborts the frame and restores requester 0 as top priority.
    $display("[TB] reset mid-frame");
    bus_a.req = 4'b0100;
    waitGrant(2, t);
    tick();
    tick();
    tick();
    reset_a   = 1'b1;
    bus_a.req = 4'b1001;
    tick();
    checkOutput("reset VO", 32'(bus_a.VO), 32'd0);
    checkOutput("reset busy", 32'(bus_a.busy), 32'd0);
    checkOutput("reset OK", 32'(bus_a.OK), 32'd0);
    checkOutput("reset owner", 32'(bus_a.owner), 32'd0);
    checkOutput("reset grant", 32'(bus_a.grant), 32'd0);
    checkOutput("reset sout", 32'(bus_a.sout), 32'd0);
    reset_a = 1'b0;
    t_rel   = cycle_cnt;
    waitGrant(0, t);
    checkOutput("grant latency after reset", 32'(t - t_rel), 32'd1);
    bus_a.req = '0;
    captureFrame(8'h01, -1);

    // Request dropped at bit 2 still completes the frame, then the lane idles.
    $display("[TB] request dropped mid-frame");
    bus_a.req = 4'b0010;
    waitGrant(1, t);
    captureFrame(8'h02, 2);
    tick();
    checkOutput("OK single pulse", 32'(bus_a.OK), 32'd0);
    checkOutput("idle busy", 32'(bus_a.busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("idle %0d busy", k), 32'(bus_a.busy), 32'd0);
      checkOutput($sformatf("idle %0d grant", k), 32'(bus_a.grant), 32'd0);
      checkOutput($sformatf("idle %0d VO", k), 32'(bus_a.VO), 32'd0);
    end

    // GAP=0, WIDTH=4, N_REQ=2: back-to-back frames 0x9 / 0x6 every 5 cycles.
    $display("[TB] GAP=0 back-to-back");
    bus_b.req     = 2'b11;
    bus_b.data_in = {4'h6, 4'h9};
    tick();
    checkOutput("B reset busy", 32'(bus_b.busy), 32'd0);
    checkOutput("B reset VO", 32'(bus_b.VO), 32'd0);
    checkOutput("B reset owner", 32'(bus_b.owner), 32'd0);
    reset_b = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      p      = (c - 1) % 5;
      f      = (c - 1) / 5;
      own    = f % 2;
      word_b = (own == 1) ? 4'h6 : 4'h9;
      if (p < 4) begin
        exp_grant_b = (p == 0) ? 2'(1 << own) : 2'b00;
        exp_vo_b    = 1'b1;
        exp_sout_b  = word_b[3-p];
        exp_ok_b    = 1'b0;
        exp_busy_b  = 1'b1;
      end else begin
        exp_grant_b = 2'b00;
        exp_vo_b    = 1'b0;
        exp_sout_b  = 1'b0;
        exp_ok_b    = 1'b1;
        exp_busy_b  = 1'b0;
      end
      checkOutput($sformatf("B c%0d grant", c), 32'(bus_b.grant), 32'(exp_grant_b));
      checkOutput($sformatf("B c%0d VO", c), 32'(bus_b.VO), 32'(exp_vo_b));
      checkOutput($sformatf("B c%0d sout", c), 32'(bus_b.sout), 32'(exp_sout_b));
      checkOutput($sformatf("B c%0d OK", c), 32'(bus_b.OK), 32'(exp_ok_b));
      checkOutput($sformatf("B c%0d busy", c), 32'(bus_b.busy), 32'(exp_busy_b));
      checkOutput($sformatf("B c%0d owner", c), 32'(bus_b.owner), 32'(own));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/p2s_tx_scheduler.md
Name: p2s_tx_scheduler

Overview:
Shares one parallel-to-serial transmit lane between N_REQ requesters. Each requester presents a WIDTH-bit word with a request. A round-robin scheduler picks one requester, latches its word and shifts it out MSB-first with a valid strobe. After each frame it inserts a programmable idle gap and re-arms; it never parks in a terminal state. It sits between the word producers and the serial line driver.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, bits per frame (2..16)
GAP, 1, idle cycles after each frame (0..15)
OW, derived = max(1, clog2(N_REQ)), width of owner index

Ports:
ck  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level
data_in  in  N_REQ*WIDTH  word of requester i on bits [i*WIDTH +: WIDTH]
grant  out  N_REQ  one-hot, one-cycle pulse acknowledging the latched word
sout  out  1  serial data, MSB first
VO  out  1  high while sout carries a valid frame bit
frame_start  out  1  high with the first bit (MSB) of each frame
OK  out  1  one-cycle pulse in the cycle after the last bit
busy  out  1  high in every state except IDLE
owner  out  OW  index of the requester whose frame is in flight or most recently sent

Behaviour:
- Clock and reset: one clock (ck). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE; grant=0; sout=0; VO=0; frame_start=0; OK=0; busy=0; owner=0.
- Reset also sets the shift register, bit counter and gap counter to 0 and the priority pointer to 0, so requester 0 has highest priority.
- Reset has priority over all other activity. Reset during SHIFT aborts the frame, and VO falls on the next edge.
- States: IDLE, SHIFT, GAP. Use one-hot encoding. An illegal encoding goes to IDLE.
- IDLE, selection:
  - If any req bit is high, pick the first set bit at or above ptr, searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - On the edge that leaves IDLE: latch that requester's word into the shift register, set owner to its index, set ptr=(owner+1) mod N_REQ, set counter=0, go to SHIFT.
  - If no req bit is high, stay in IDLE.
- Grant: a registered pulse, high only in the first SHIFT cycle. A requester holds req and data_in stable until it sees grant, then may drop req or present the next word.
- SHIFT: VO=1 and sout=shreg[WIDTH-1] every cycle. frame_start=1 only when counter=0.
  - Each edge: shift left by 1 and increment counter.
  - When counter=WIDTH-1 at the edge: go to GAP if GAP>0, otherwise to IDLE.
  - In both cases OK=1 for exactly the next cycle.
- Input changes during SHIFT/GAP: req and data_in are ignored. Dropping a request mid-frame does not abort the frame.
- GAP: VO=0, sout=0. Hold GAP cycles counted by gap counter, then go to IDLE.
- Latency: req seen in IDLE at edge k → grant and MSB valid in cycle k+1. The last bit is in cycle k+WIDTH.
- Frame spacing: WIDTH+GAP+1 cycles per frame with continuous requests (one IDLE selection cycle per frame).
- Other outputs: sout=0 whenever VO=0. busy=1 in SHIFT and GAP. owner holds its value through IDLE until the next selection.
- Widths: counter is clog2(WIDTH)+1 bits; gap counter is 4 bits. The ptr increment wraps N_REQ-1 → 0 with no out-of-range value.

Test Plan:
1. Single requester: reset 2 cycles; req=4'b0010, word1=8'hA5.
   - Expect grant=4'b0010 one cycle later.
   - sout=1,0,1,0,0,1,0,1 over 8 cycles with VO=1; frame_start only on the first bit.
   - OK pulse next cycle; then 1 GAP cycle; owner=1.
2. Round-robin: req=4'b1111 held, words 8'h01/8'h02/8'h03/8'h04.
   - Expect grants in order 0,1,2,3,0.
   - Frame period of 10 cycles (WIDTH 8 + GAP 1 + 1).
3. Pointer wrap and skip: after a grant to 3, set req=4'b0101. Expect the next grant to 0, then 2, then 0.
4. Reset mid-frame: assert reset at bit 3 of a frame.
   - Next cycle: VO=0, busy=0, OK stays 0, owner=0.
   - After release with req=4'b1000 and 4'b0001 both high, grant goes to 0 first.
5. Request dropped mid-frame: req deasserted at bit 2. The frame completes all 8 bits, OK pulses, and the scheduler then idles.
6. GAP=0, WIDTH=4, N_REQ=2, continuous req=2'b11.
   - Frames are back-to-back, separated only by one IDLE cycle.
   - Grants alternate 0,1; OK pulses coincide with the IDLE cycle.
